branch_redirect_fifo: RTL and testbench

//  Buffers resolved branch redirects (thread id + target PC) from execute and presents the oldest to the
//  PC-select stage directly downstream. First-word-fall-through queue: head drives br_pc/br_thread_id/

---
 rtl/branch_redirect_fifo.sv | 83 ++++++++
 tb/tb_branch_redirect_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_fifo.sv
// branch_redirect_fifo: FWFT queue of branch redirects (thread id + target PC) feeding the PC-select stage; optional BRANCH_FIFO_COALESCE_EN merges pushes into a pending entry of the same thread
`ifndef XLEN
`define XLEN 32
`endif
module branch_redirect_fifo #(
  parameter int DEPTH = 8,
  parameter int TID_W = 3,
  parameter int PC_W  = `XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid_i,
  input  logic [TID_W-1:0]         push_thread_id_i,
  input  logic [PC_W-1:0]          push_pc_i,
  input  logic                     br_ack_i,
  output logic [PC_W-1:0]          br_pc_o,
  output logic [TID_W-1:0]         br_thread_id_o,
  output logic                     branch_fifo_empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PC_W-1:0]  mem_pc  [DEPTH];
  logic [TID_W-1:0] mem_tid [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, hit_idx, wsel;
  logic [CW-1:0]    count;
  logic             empty, full, pop, hit, alloc;
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign pop   = br_ack_i && !empty;
  assign alloc = push_valid_i && !hit && (!full || br_ack_i);
  assign wsel  = hit ? hit_idx : wr_ptr;
`ifdef BRANCH_FIFO_COALESCE_EN
  logic [PW-1:0] off [DEPTH];
  // find the pending entry of the pushing thread, ignoring a head that retires this cycle
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = PW'(i) - rd_ptr;
      if (push_valid_i && {1'b0, off[i]} < count && mem_tid[i] == push_thread_id_i && !(pop && off[i] == '0)) begin
        hit = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_idx = '0;
`endif
  assign branch_fifo_empty_o = empty;
  assign full_o              = full;
  assign count_o             = count;
  assign br_pc_o             = empty ? '0 : mem_pc[rd_ptr];
  assign br_thread_id_o      = empty ? '0 : mem_tid[rd_ptr];
  // storage, pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]  <= '0;
        mem_tid[i] <= '0;
      end
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (alloc || hit) begin
        mem_pc[wsel]  <= push_pc_i;
        mem_tid[wsel] <= push_thread_id_i;
      end
      if (alloc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count       <= count + CW'(alloc) - CW'(pop);
      overflow_o  <= overflow_o | (push_valid_i && !hit && full && !br_ack_i);
      underflow_o <= underflow_o | (br_ack_i && empty);
    end
  end
endmodule

// File: tb/tb_branch_redirect_fifo.sv
// tb_branch_redirect_fifo: directed scenarios plus random traffic checked against a queue model
`ifndef XLEN
`define XLEN 32
`endif
module tb_branch_redirect_fifo;
  typedef struct packed {logic [2:0] tid; logic [31:0] pc;} ent_t;
  logic clk = 0, rst = 0, push_valid = 0, ack = 0;
  logic [2:0] push_tid = '0;
  logic [31:0] push_pc = '0;
  logic [31:0] br_pc;
  logic [2:0] br_tid;
  logic empty, full, ovf, unf;
  logic [3:0] count;
  logic [42:0] obs;
  ent_t q[$];
  bit m_ovf, m_unf;
  int checks = 0, fails = 0;

  branch_redirect_fifo #(.DEPTH(8), .TID_W(3), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .push_valid_i(push_valid), .push_thread_id_i(push_tid),
    .push_pc_i(push_pc), .br_ack_i(ack), .br_pc_o(br_pc), .br_thread_id_o(br_tid),
    .branch_fifo_empty_o(empty), .full_o(full), .count_o(count),
    .overflow_o(ovf), .underflow_o(unf));

  always #5 clk = ~clk;
  assign obs = {count, empty, full, ovf, unf, br_tid, br_pc};

  function automatic logic [42:0] exp_vec();
    int n = q.size();
    return {4'(n), n == 0, n == 8, m_ovf, m_unf, n > 0 ? q[0].tid : 3'd0, n > 0 ? q[0].pc : 32'd0};
  endfunction

  task automatic model(input logic pv, input logic [2:0] t, input logic [31:0] p, input logic a);
    int n = q.size();
    bit popping = a && n > 0;
    bit merged = 0;
`ifdef BRANCH_FIFO_COALESCE_EN
    if (pv) for (int j = popping ? 1 : 0; j < n; j++) if (!merged && q[j].tid == t) begin q[j].pc = p; merged = 1; end
`endif
    if (a && n == 0) m_unf = 1;
    if (pv && !merged && n == 8 && !a) m_ovf = 1;
    if (popping) void'(q.pop_front());
    if (pv && !merged && (n < 8 || a)) q.push_back('{t, p});
  endtask

  task automatic step(input logic pv, input logic [2:0] t, input logic [31:0] p, input logic a);
    @(negedge clk);
    push_valid = pv; push_tid = t; push_pc = p; ack = a;
    @(posedge clk);
    model(pv, t, p, a);
    #1;
    push_valid = 0; ack = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0}) begin fails++; $display("FAIL reset_state: got %h expected %h", obs, {4'd0, 1'b1, 38'd0}); end
    @(negedge clk) rst = 1;
  endtask

  task automatic test_basic();
    step(1, 3'd2, 32'h100, 0);
    checks++;
    if ({br_tid, br_pc, empty} !== {3'd2, 32'h100, 1'b0}) begin fails++; $display("FAIL basic_head1: got %0d/%h expected 2/100", br_tid, br_pc); end
    step(1, 3'd5, 32'h200, 0);
    checks++;
    if (obs !== exp_vec()) begin fails++; $display("FAIL basic_two: got %h expected %h", obs, exp_vec()); end
    step(0, 0, 0, 1);
    checks++;
    if ({br_tid, br_pc} !== {3'd5, 32'h200}) begin fails++; $display("FAIL basic_head2: got %0d/%h expected 5/200", br_tid, br_pc); end
    step(0, 0, 0, 1);
    checks++;
    if (empty !== 1'b1 || obs !== exp_vec()) begin fails++; $display("FAIL basic_drain: got %h expected %h", obs, exp_vec()); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 8; i++) step(1, 3'(i), 32'h1000 + 32'(i * 4), 0);
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || obs !== exp_vec()) begin fails++; $display("FAIL fill: got %h expected %h", obs, exp_vec()); end
    step(1, 3'd1, 32'h40, 0);
    checks++;
    if ({count, full, br_tid, br_pc} !== {4'd8, 1'b1, 3'd0, 32'h1000}) begin fails++; $display("FAIL full_push_head: got %h expected %h", {count, full, br_tid, br_pc}, {4'd8, 1'b1, 3'd0, 32'h1000}); end
    checks++;
`ifdef BRANCH_FIFO_COALESCE_EN
    if (ovf !== 1'b0) begin fails++; $display("FAIL full_push_ovf: got %b expected 0", ovf); end
`else
    if (ovf !== 1'b1) begin fails++; $display("FAIL full_push_ovf: got %b expected 1", ovf); end
`endif
  endtask

  task automatic test_full_push_pop();
    step(1, 3'd3, 32'h80, 1);
    checks++;
`ifdef BRANCH_FIFO_COALESCE_EN
    if (count !== 4'd7) begin fails++; $display("FAIL full_pushpop_count: got %0d expected 7", count); end
`else
    if (count !== 4'd8) begin fails++; $display("FAIL full_pushpop_count: got %0d expected 8", count); end
`endif
    for (int g = 0; g < 10 && q.size() > 0; g++) begin
`ifndef BRANCH_FIFO_COALESCE_EN
      if (q.size() == 1) begin
        checks++;
        if ({br_tid, br_pc} !== {3'd3, 32'h80}) begin fails++; $display("FAIL last_out: got %0d/%h expected 3/80", br_tid, br_pc); end
      end
`endif
      step(0, 0, 0, 1);
      checks++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL drain_%0d: got %h expected %h", g, obs, exp_vec()); end
    end
  endtask

  task automatic test_underflow();
    step(0, 0, 0, 1);
    checks++;
    if ({unf, empty, count} !== {1'b1, 1'b1, 4'd0}) begin fails++; $display("FAIL underflow: got %b/%b/%0d expected 1/1/0", unf, empty, count); end
    step(1, 3'd0, 32'h10, 0);
    checks++;
    if ({br_tid, br_pc, count} !== {3'd0, 32'h10, 4'd1}) begin fails++; $display("FAIL after_underflow_push: got %0d/%h/%0d expected 0/10/1", br_tid, br_pc, count); end
    step(0, 0, 0, 1);
    checks++;
    if (empty !== 1'b1 || obs !== exp_vec()) begin fails++; $display("FAIL after_underflow_pop: got %h expected %h", obs, exp_vec()); end
  endtask

  task automatic test_coalesce();
    logic [31:0] want [$];
`ifdef BRANCH_FIFO_COALESCE_EN
    want = '{32'h400, 32'h500};
`else
    want = '{32'h300, 32'h500, 32'h400};
`endif
    step(1, 3'd4, 32'h300, 0);
    step(1, 3'd6, 32'h500, 0);
    step(1, 3'd4, 32'h400, 0);
    checks++;
    if (count !== 4'(want.size())) begin fails++; $display("FAIL coalesce_count: got %0d expected %0d", count, want.size()); end
    foreach (want[k]) begin
      checks++;
      if (br_pc !== want[k]) begin fails++; $display("FAIL coalesce_order_%0d: got %h expected %h", k, br_pc, want[k]); end
      step(0, 0, 0, 1);
    end
    checks++;
    if (empty !== 1'b1) begin fails++; $display("FAIL coalesce_empty: got %b expected 1", empty); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      step(($urandom_range(0, 99) < 60), 3'($urandom), $urandom, ($urandom_range(0, 99) < 45));
      checks++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL random_%0d: got %h expected %h", c, obs, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    while (q.size() > 0) step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 3'(i + 1), 32'h700 + 32'(i), 0);
    checks++;
    if (count !== 4'd3) begin fails++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
    #2 rst = 0;
    #1;
    checks++;
    if ({count, empty, br_pc, ovf, unf} !== {4'd0, 1'b1, 32'd0, 1'b0, 1'b0}) begin fails++; $display("FAIL async_reset: got %0d/%b/%h/%b/%b expected 0/1/0/0/0", count, empty, br_pc, ovf, unf); end
    q.delete(); m_ovf = 0; m_unf = 0;
    @(negedge clk) rst = 1;
    step(1, 3'd7, 32'h900, 0);
    checks++;
    if (obs !== exp_vec() || count !== 4'd1) begin fails++; $display("FAIL post_reset_push: got %h expected %h", obs, exp_vec()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_push_pop();
    test_underflow();
    test_coalesce();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
